// File: rtl/key_event_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_event_pkg
// Brief    : Shared key FSM state type and default timing constants.
// Revision : 1.0 - initial release
// ============================================================================
package key_event_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } key_state_t;

  // Defaults assume a 50 MHz clock and a 10 ms sample tick
  localparam int C_NUM_KEYS       = 4;
  localparam int C_TICK_DIV       = 500000;
  localparam int C_DEBOUNCE_TICKS = 5;
  localparam int C_LONG_TICKS     = 100;
  localparam int C_REPEAT_TICKS   = 20;

endpackage : key_event_pkg
`default_nettype wire

// File: rtl/key_event_chan.sv
`default_nettype none
// ============================================================================
// Module   : key_event_chan
// Brief    : One key: two-flop synchroniser, tick-based debounce, event FSM.
// Revision : 1.0 - initial release
// ============================================================================
module key_event_chan
  import key_event_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = C_DEBOUNCE_TICKS,
  parameter int LONG_TICKS     = C_LONG_TICKS,
  parameter int REPEAT_TICKS   = C_REPEAT_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_en,
  input  logic key_n,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int c_db_w   = $clog2(DEBOUNCE_TICKS + 1);
  localparam int c_hold_w = $clog2(LONG_TICKS + 1);
  localparam int c_rpt_w  = $clog2(REPEAT_TICKS + 1);

  localparam logic [c_db_w-1:0]   c_db_last   = c_db_w'(DEBOUNCE_TICKS - 1);
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(LONG_TICKS - 1);
  localparam logic [c_hold_w-1:0] c_hold_max  = c_hold_w'(LONG_TICKS);
  localparam logic [c_rpt_w-1:0]  c_rpt_last  = c_rpt_w'(REPEAT_TICKS - 1);

  logic                r_sync1;
  logic                r_sync2;
  logic                r_level;
  logic [c_db_w-1:0]   r_db_cnt;
  key_state_t          r_state;
  logic [c_hold_w-1:0] r_hold_cnt;
  logic [c_rpt_w-1:0]  r_rpt_cnt;
  logic                r_press;
  logic                r_release;
  logic                r_long;
  logic                r_repeat;

  logic                w_key_s;
  logic                w_level_next;
  logic [c_db_w-1:0]   w_db_next;
  logic                w_rise;
  logic                w_fall;
  key_state_t          w_state_next;
  logic [c_hold_w-1:0] w_hold_next;
  logic [c_rpt_w-1:0]  w_rpt_next;
  logic                w_press_d;
  logic                w_release_d;
  logic                w_long_d;
  logic                w_repeat_d;

  assign w_key_s = ~r_sync2;

  // Synchroniser resets to the released level so no phantom press follows reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_level  <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      if (tick_en) begin
        r_level  <= w_level_next;
        r_db_cnt <= w_db_next;
      end
    end
  end

  always_comb begin
    w_level_next = r_level;
    w_db_next    = '0;
    if (w_key_s != r_level) begin
      if (r_db_cnt == c_db_last) begin
        w_level_next = ~r_level;
      end else begin
        w_db_next = r_db_cnt + 1'b1;
      end
    end
  end

  assign w_rise = tick_en & ~r_level &  w_level_next;
  assign w_fall = tick_en &  r_level & ~w_level_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_rpt_cnt  <= '0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_long     <= 1'b0;
      r_repeat   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_hold_cnt <= w_hold_next;
      r_rpt_cnt  <= w_rpt_next;
      r_press    <= w_press_d;
      r_release  <= w_release_d;
      r_long     <= w_long_d;
      r_repeat   <= w_repeat_d;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_hold_next  = r_hold_cnt;
    w_rpt_next   = r_rpt_cnt;
    if (tick_en) begin
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            w_state_next = HELD;
            w_hold_next  = '0;
          end
        end
        HELD: begin
          if (w_fall) begin
            w_state_next = IDLE;
            w_hold_next  = '0;
          end else if (r_hold_cnt == c_hold_last) begin
            // Hold counter parks at LONG_TICKS for the rest of the hold
            w_state_next = LONG;
            w_hold_next  = c_hold_max;
            w_rpt_next   = '0;
          end else begin
            w_hold_next = r_hold_cnt + 1'b1;
          end
        end
        LONG: begin
          if (w_fall) begin
            w_state_next = IDLE;
            w_hold_next  = '0;
            w_rpt_next   = '0;
          end else if (r_rpt_cnt == c_rpt_last) begin
            w_rpt_next = '0;
          end else begin
            w_rpt_next = r_rpt_cnt + 1'b1;
          end
        end
        default: begin
          w_state_next = IDLE;
          w_hold_next  = '0;
          w_rpt_next   = '0;
        end
      endcase
    end
  end

  // A release on the same tick suppresses any long or repeat event
  always_comb begin
    w_press_d   = 1'b0;
    w_release_d = 1'b0;
    w_long_d    = 1'b0;
    w_repeat_d  = 1'b0;
    case (r_state)
      IDLE: w_press_d = w_rise;
      HELD: begin
        w_release_d = w_fall;
        w_long_d    = tick_en & ~w_fall & (r_hold_cnt == c_hold_last);
      end
      LONG: begin
        w_release_d = w_fall;
        w_repeat_d  = tick_en & ~w_fall & (r_rpt_cnt == c_rpt_last);
      end
      default: ;
    endcase
  end

  assign key_level     = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign long_pulse    = r_long;
  assign repeat_pulse  = r_repeat;

endmodule : key_event_chan
`default_nettype wire

// File: rtl/key_event_gen.sv
`default_nettype none
// ============================================================================
// Module   : key_event_gen
// Brief    : Shared sample-tick divider feeding NUM_KEYS independent key channels.
// Revision : 1.0 - initial release
// ============================================================================
module key_event_gen
  import key_event_pkg::*;
#(
  parameter int NUM_KEYS       = C_NUM_KEYS,
  parameter int TICK_DIV       = C_TICK_DIV,
  parameter int DEBOUNCE_TICKS = C_DEBOUNCE_TICKS,
  parameter int LONG_TICKS     = C_LONG_TICKS,
  parameter int REPEAT_TICKS   = C_REPEAT_TICKS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] long_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse
);

  localparam int                  c_tick_w    = $clog2(TICK_DIV + 1);
  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);

  logic [c_tick_w-1:0] r_tick_cnt;
  logic                w_tick_en;

  assign w_tick_en = (r_tick_cnt == c_tick_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_cnt <= '0;
    end else if (w_tick_en) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  generate
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
      key_event_chan #(
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
        .LONG_TICKS     (LONG_TICKS),
        .REPEAT_TICKS   (REPEAT_TICKS)
      ) u_chan (
        .clk           (clk),
        .reset         (reset),
        .tick_en       (w_tick_en),
        .key_n         (key_n[g]),
        .key_level     (key_level[g]),
        .press_pulse   (press_pulse[g]),
        .release_pulse (release_pulse[g]),
        .long_pulse    (long_pulse[g]),
        .repeat_pulse  (repeat_pulse[g])
      );
    end
  endgenerate

endmodule : key_event_gen
`default_nettype wire
